// File: rtl/uart_cmd_responder_pkg.sv
// rtl/uart_cmd_responder_pkg.sv - opcodes, reply bytes and FSM state encoding for uart_cmd_responder
package uart_cmd_responder_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_W_ADDR,
        ST_W_DATA,
        ST_BUS_WR,
        ST_R_ADDR,
        ST_BUS_RD,
        ST_RD_WAIT,
        ST_TX_REQ,
        ST_TX_HOLD,
        ST_TX_WAIT
    } state_t;

    // States that may consume a byte from the UART receiver.
    function automatic logic state_accepts_rx(input state_t s);
        return (s == ST_IDLE) || (s == ST_W_ADDR) || (s == ST_W_DATA) || (s == ST_R_ADDR);
    endfunction

    // States waiting for the next byte of a partially received command.
    function automatic logic state_mid_command(input state_t s);
        return (s == ST_W_ADDR) || (s == ST_W_DATA) || (s == ST_R_ADDR);
    endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// rtl/uart_byte_timeout.sv - saturating inter-byte timeout counter
module uart_byte_timeout #(
    parameter int            TN      = 16,
    parameter logic [TN-1:0] Timeout = 16'd50000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TN-1:0] LAST = Timeout - TN'(1);

    logic [TN-1:0] cnt_q;
    logic [TN-1:0] cnt_d;

    assign expired = (cnt_q >= LAST);

    // Stops at LAST so a long stall can never wrap back to a small count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + TN'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - parses W/R commands from UART bytes, drives the register bus, returns one reply byte
module uart_cmd_responder
    import uart_cmd_responder_pkg::*;
#(
    parameter int            TN      = 16,
    parameter logic [TN-1:0] Timeout = 16'd50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] Rx_Data,
    input  logic       Rx_Ready,
    output logic       Rx_Ack,
    output logic [7:0] Tx_Data,
    output logic       Tx_Send,
    input  logic       Tx_Busy,
    output logic [7:0] Bus_Address,
    output logic [7:0] Bus_WrData,
    output logic       Bus_Write,
    output logic       Bus_Read,
    input  logic [7:0] Bus_RdData,
    output logic       Busy
);

    state_t     state_q, state_d;
    logic       ack_q;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wrdata_q, wrdata_d;

    logic rx_take;
    logic mid_cmd;
    logic expired;
    logic bus_write;
    logic bus_read;
    logic tx_send;

    // ack_q blanks Rx_Ready for the cycle after an Ack, while the UART is still dropping it.
    assign rx_take = Reset && Rx_Ready && !ack_q && state_accepts_rx(state_q);
    assign mid_cmd = state_mid_command(state_q);

    uart_byte_timeout #(
        .TN      (TN),
        .Timeout (Timeout)
    ) u_timeout (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear   (rx_take || !mid_cmd),
        .enable  (mid_cmd),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        addr_d    = addr_q;
        wrdata_d  = wrdata_q;
        bus_write = 1'b0;
        bus_read  = 1'b0;
        tx_send   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_take) begin
                    if (Rx_Data == OP_WRITE) begin
                        state_d = ST_W_ADDR;
                    end else if (Rx_Data == OP_READ) begin
                        state_d = ST_R_ADDR;
                    end else begin
                        tx_data_d = RSP_ERR;
                        state_d   = ST_TX_REQ;
                    end
                end
            end
            ST_W_ADDR: begin
                if (rx_take) begin
                    addr_d  = Rx_Data;
                    state_d = ST_W_DATA;
                end else if (expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_W_DATA: begin
                if (rx_take) begin
                    wrdata_d = Rx_Data;
                    state_d  = ST_BUS_WR;
                end else if (expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS_WR: begin
                bus_write = 1'b1;
                tx_data_d = RSP_OK;
                state_d   = ST_TX_REQ;
            end
            ST_R_ADDR: begin
                if (rx_take) begin
                    addr_d  = Rx_Data;
                    state_d = ST_BUS_RD;
                end else if (expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS_RD: begin
                bus_read = 1'b1;
                state_d  = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                tx_data_d = Bus_RdData;
                state_d   = ST_TX_REQ;
            end
            ST_TX_REQ: begin
                if (!Tx_Busy) begin
                    tx_send = 1'b1;
                    state_d = ST_TX_HOLD;
                end
            end
            // The UART needs a cycle to raise Tx_Busy after the send pulse.
            ST_TX_HOLD: begin
                state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (!Tx_Busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            tx_data_q <= 8'h00;
            addr_q    <= 8'h00;
            wrdata_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            ack_q     <= rx_take;
            tx_data_q <= tx_data_d;
            addr_q    <= addr_d;
            wrdata_q  <= wrdata_d;
        end
    end

    assign Rx_Ack      = rx_take;
    assign Tx_Data     = tx_data_q;
    assign Tx_Send     = tx_send;
    assign Bus_Address = addr_q;
    assign Bus_WrData  = wrdata_q;
    assign Bus_Write   = bus_write;
    assign Bus_Read    = bus_read;
    assign Busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb/tb_uart_cmd_responder.sv - self-checking bench for uart_cmd_responder
module tb_uart_cmd_responder;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] Rx_Data;
    logic       Rx_Ready;
    logic       Rx_Ack;
    logic [7:0] Tx_Data;
    logic       Tx_Send;
    logic       Tx_Busy;
    logic [7:0] Bus_Address;
    logic [7:0] Bus_WrData;
    logic       Bus_Write;
    logic       Bus_Read;
    logic [7:0] Bus_RdData;
    logic       Busy;

    always #5 Clk = ~Clk;

    uart_cmd_responder #(
        .TN      (16),
        .Timeout (16'd20)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Rx_Data     (Rx_Data),
        .Rx_Ready    (Rx_Ready),
        .Rx_Ack      (Rx_Ack),
        .Tx_Data     (Tx_Data),
        .Tx_Send     (Tx_Send),
        .Tx_Busy     (Tx_Busy),
        .Bus_Address (Bus_Address),
        .Bus_WrData  (Bus_WrData),
        .Bus_Write   (Bus_Write),
        .Bus_Read    (Bus_Read),
        .Bus_RdData  (Bus_RdData),
        .Busy        (Busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples at the falling edge, away from the active edge.
    int         cyc_n = 0;
    int         ack_cnt = 0, wr_cnt = 0, rd_cnt = 0, send_cnt = 0, both_cnt = 0;
    int         ack_cyc = 0, wr_cyc = 0, rd_cyc = 0, send_cyc = 0;
    logic [7:0] cap_addr = 8'h00, cap_wd = 8'h00, cap_tx = 8'h00;

    always @(negedge Clk) begin
        cyc_n <= cyc_n + 1;
        if (Rx_Ack === 1'b1) begin
            ack_cnt <= ack_cnt + 1;
            ack_cyc <= cyc_n + 1;
        end
        if (Bus_Write === 1'b1) begin
            wr_cnt   <= wr_cnt + 1;
            wr_cyc   <= cyc_n + 1;
            cap_addr <= Bus_Address;
            cap_wd   <= Bus_WrData;
        end
        if (Bus_Read === 1'b1) begin
            rd_cnt   <= rd_cnt + 1;
            rd_cyc   <= cyc_n + 1;
            cap_addr <= Bus_Address;
        end
        if (Tx_Send === 1'b1) begin
            send_cnt <= send_cnt + 1;
            send_cyc <= cyc_n + 1;
            cap_tx   <= Tx_Data;
        end
        if (Bus_Write === 1'b1 && Bus_Read === 1'b1) begin
            both_cnt <= both_cnt + 1;
        end
    end

    // Register bus model: read data valid only in the cycle after Bus_Read.
    logic [7:0] rd_value = 8'h00;
    initial begin
        Bus_RdData = 8'hEE;
        forever begin
            @(negedge Clk);
            if (Bus_Read === 1'b1) begin
                @(posedge Clk);
                #1 Bus_RdData = rd_value;
                @(posedge Clk);
                #1 Bus_RdData = 8'hEE;
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input int limit);
        int n = 0;
        Rx_Data  = b;
        Rx_Ready = 1'b1;
        #1;
        while (Rx_Ack !== 1'b1 && n < limit) begin
            cyc();
            #1;
            n++;
        end
        if (Rx_Ack !== 1'b1) begin
            check("rx_ack_wait", 32'(n), 32'(limit + 1));
            Rx_Ready = 1'b0;
        end else begin
            cyc();
            Rx_Ready = 1'b0;
        end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (Busy !== 1'b0 && n < limit) begin
            cyc();
            n++;
        end
        check("idle_wait", 32'(Busy), 32'(0));
    endtask

    typedef struct {
        int         nb;
        logic [7:0] b0, b1, b2;
        logic [7:0] rd;
        int         exp_wr, exp_rd;
        logic [7:0] ea, ed, etx;
        int         lat;
    } vec_t;

    vec_t vt[6];

    int         b_ack, b_wr, b_rd, b_send;
    logic [7:0] bs[3];

    initial begin
        vt[0] = '{3, 8'h57, 8'h10, 8'hA5, 8'h00, 1, 0, 8'h10, 8'hA5, 8'h4B, 2};
        vt[1] = '{2, 8'h52, 8'h22, 8'h00, 8'h3C, 0, 1, 8'h22, 8'h00, 8'h3C, 3};
        vt[2] = '{1, 8'h41, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h3F, 1};
        vt[3] = '{3, 8'h57, 8'hFF, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00, 8'h4B, 2};
        vt[4] = '{2, 8'h52, 8'h10, 8'h00, 8'hA5, 0, 1, 8'h10, 8'h00, 8'hA5, 3};
        vt[5] = '{1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 8'h3F, 1};

        Reset    = 1'b0;
        Rx_Data  = 8'h57;
        Rx_Ready = 1'b1;
        Tx_Busy  = 1'b0;
        #2;
        check("rst_rx_ack", 32'(Rx_Ack), 0);
        check("rst_tx_send", 32'(Tx_Send), 0);
        check("rst_bus_write", 32'(Bus_Write), 0);
        check("rst_bus_read", 32'(Bus_Read), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_tx_data", 32'(Tx_Data), 0);
        check("rst_bus_addr", 32'(Bus_Address), 0);
        check("rst_bus_wrdata", 32'(Bus_WrData), 0);
        Rx_Ready = 1'b0;
        cyc();
        cyc();
        Reset = 1'b1;
        cyc();

        for (int i = 0; i < 6; i++) begin
            b_ack = ack_cnt; b_wr = wr_cnt; b_rd = rd_cnt; b_send = send_cnt;
            rd_value = vt[i].rd;
            bs[0] = vt[i].b0; bs[1] = vt[i].b1; bs[2] = vt[i].b2;
            for (int k = 0; k < vt[i].nb; k++) begin
                send_byte(bs[k], 10);
            end
            wait_idle(20);
            check($sformatf("v%0d_acks", i), 32'(ack_cnt - b_ack), 32'(vt[i].nb));
            check($sformatf("v%0d_writes", i), 32'(wr_cnt - b_wr), 32'(vt[i].exp_wr));
            check($sformatf("v%0d_reads", i), 32'(rd_cnt - b_rd), 32'(vt[i].exp_rd));
            check($sformatf("v%0d_sends", i), 32'(send_cnt - b_send), 1);
            check($sformatf("v%0d_tx_data", i), 32'(cap_tx), 32'(vt[i].etx));
            check($sformatf("v%0d_send_lat", i), 32'(send_cyc - ack_cyc), 32'(vt[i].lat));
            if (vt[i].exp_wr == 1) begin
                check($sformatf("v%0d_wr_addr", i), 32'(cap_addr), 32'(vt[i].ea));
                check($sformatf("v%0d_wr_data", i), 32'(cap_wd), 32'(vt[i].ed));
                check($sformatf("v%0d_wr_lat", i), 32'(wr_cyc - ack_cyc), 1);
            end
            if (vt[i].exp_rd == 1) begin
                check($sformatf("v%0d_rd_addr", i), 32'(cap_addr), 32'(vt[i].ea));
                check($sformatf("v%0d_rd_lat", i), 32'(rd_cyc - ack_cyc), 1);
            end
            cyc();
        end
        check("addr_hold", 32'(Bus_Address), 32'h10);
        check("wrdata_hold", 32'(Bus_WrData), 32'h00);

        // Inter-byte timeout abandons a partial write.
        b_wr = wr_cnt; b_send = send_cnt; b_rd = rd_cnt;
        send_byte(8'h57, 10);
        send_byte(8'h10, 10);
        repeat (15) cyc();
        check("to_busy_before", 32'(Busy), 1);
        repeat (10) cyc();
        check("to_busy_after", 32'(Busy), 0);
        check("to_no_write", 32'(wr_cnt - b_wr), 0);
        check("to_no_send", 32'(send_cnt - b_send), 0);
        rd_value = 8'h5A;
        send_byte(8'h52, 10);
        send_byte(8'h10, 10);
        wait_idle(20);
        check("to_read_after", 32'(rd_cnt - b_rd), 1);
        check("to_read_addr", 32'(cap_addr), 32'h10);
        check("to_read_tx", 32'(cap_tx), 32'h5A);

        // Transmitter back-pressure; a byte arriving meanwhile stays pending.
        b_ack = ack_cnt; b_wr = wr_cnt; b_send = send_cnt; b_rd = rd_cnt;
        Tx_Busy = 1'b1;
        send_byte(8'h57, 10);
        send_byte(8'h01, 10);
        send_byte(8'h02, 10);
        Rx_Data  = 8'h52;
        Rx_Ready = 1'b1;
        repeat (100) cyc();
        check("bp_acks", 32'(ack_cnt - b_ack), 3);
        check("bp_write", 32'(wr_cnt - b_wr), 1);
        check("bp_no_send", 32'(send_cnt - b_send), 0);
        check("bp_busy", 32'(Busy), 1);
        Tx_Busy = 1'b0;
        send_byte(8'h52, 10);
        check("bp_send_once", 32'(send_cnt - b_send), 1);
        check("bp_tx_ok", 32'(cap_tx), 32'h4B);
        rd_value = 8'h77;
        send_byte(8'h33, 10);
        wait_idle(20);
        check("bp_pending_read", 32'(rd_cnt - b_rd), 1);
        check("bp_pending_addr", 32'(cap_addr), 32'h33);
        check("bp_pending_tx", 32'(cap_tx), 32'h77);

        // Reset in the middle of a write command.
        b_wr = wr_cnt; b_send = send_cnt;
        send_byte(8'h57, 10);
        send_byte(8'h05, 10);
        check("mid_busy_before", 32'(Busy), 1);
        Reset = 1'b0;
        #1;
        check("mid_rst_busy", 32'(Busy), 0);
        check("mid_rst_addr", 32'(Bus_Address), 0);
        check("mid_rst_tx_data", 32'(Tx_Data), 0);
        check("mid_rst_wrdata", 32'(Bus_WrData), 0);
        cyc();
        Reset = 1'b1;
        repeat (10) cyc();
        check("mid_no_write", 32'(wr_cnt - b_wr), 0);
        check("mid_no_send", 32'(send_cnt - b_send), 0);
        check("never_both_strobes", 32'(both_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
User-side endpoint of the UART byte interface. It consumes received bytes through the Rx_Data/Rx_Ready/Rx_Ack handshake and parses 2- or 3-byte commands. It executes each command as a read or write on a simple 8-bit register bus. It returns a single reply byte through the Tx_Data/Tx_Send/Tx_Busy handshake. It sits between the UART block and the design's control registers, giving a PC host register access.

Parameters:
TN, 16, width of the inter-byte timeout counter
Timeout, 16'd50000, number of Clk cycles allowed between bytes of one command before the partial command is discarded

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset  input  1  asynchronous, active-low reset
Rx_Data  input  8  received byte from the UART
Rx_Ready  input  1  level; a received byte is waiting
Rx_Ack  output  1  one-cycle pulse; consumes the current Rx byte
Tx_Data  output  8  reply byte to the UART
Tx_Send  output  1  one-cycle pulse; requests transmission of Tx_Data
Tx_Busy  input  1  UART transmitter is busy
Bus_Address  output  8  register address
Bus_WrData  output  8  write data
Bus_Write  output  1  one-cycle write strobe
Bus_Read  output  1  one-cycle read strobe
Bus_RdData  input  8  read data, valid the cycle after Bus_Read
Busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (Reset low, asynchronous): state IDLE. Rx_Ack, Tx_Send, Bus_Write, Bus_Read and Busy are 0. Tx_Data, Bus_Address, Bus_WrData are 8'h00. Timeout counter is 0.
- Protocol:
  - Write: 8'h57 ('W'), address, data. Performs a bus write, then replies 8'h4B ('K').
  - Read: 8'h52 ('R'), address. Performs a bus read, then replies with the read data.
  - Any other first byte: reply 8'h3F ('?') and return to IDLE.
- Rx handshake: a byte is taken only when Rx_Ready=1 and Rx_Ack was 0 in the previous cycle. Rx_Ack pulses high in the same cycle the byte is latched. Rx_Ready is ignored during the cycle after an Ack, so one byte is never consumed twice.
- Tx handshake:
  - Tx_Send pulses only when Tx_Busy=0; Tx_Data is stable from that cycle until the next send.
  - After the pulse, the block waits one cycle, then waits for Tx_Busy=0 before returning to IDLE.
- States:
  - IDLE: on a byte, latch the opcode. 'W' goes to W_ADDR, 'R' goes to R_ADDR, anything else loads Tx_Data=8'h3F and goes to TX_REQ.
  - W_ADDR: on a byte, latch Bus_Address and go to W_DATA.
  - W_DATA: on a byte, latch Bus_WrData and go to BUS_WR.
  - BUS_WR: Bus_Write=1 for exactly one cycle, load Tx_Data=8'h4B, go to TX_REQ.
  - R_ADDR: on a byte, latch Bus_Address and go to BUS_RD.
  - BUS_RD: Bus_Read=1 for exactly one cycle, go to RD_WAIT.
  - RD_WAIT: latch Bus_RdData into Tx_Data, go to TX_REQ.
  - TX_REQ: wait for Tx_Busy=0, pulse Tx_Send, go to TX_HOLD.
  - TX_HOLD: one cycle, go to TX_WAIT.
  - TX_WAIT: when Tx_Busy=0, go to IDLE.
- Latency:
  - The bus strobe is asserted 1 cycle after the final command byte is accepted.
  - For a write, Tx_Send is asserted 2 cycles after the final byte if Tx_Busy=0.
  - For a read, Tx_Send is asserted 3 cycles after the final byte if Tx_Busy=0.
- Timeout:
  - The counter clears on every accepted byte and increments each cycle in W_ADDR, W_DATA and R_ADDR.
  - When it reaches Timeout-1, the state returns to IDLE with no bus access and no reply. The counter saturates and cannot wrap.
  - The counter is held at 0 in all other states.
- Rx bytes arriving while in BUS_*, RD_WAIT or TX_*: not acknowledged. They remain pending in the UART and are handled from IDLE afterwards.
- Bus_Address and Bus_WrData hold their last values between commands. Bus_Write and Bus_Read are never high together.
- Reset mid-command: immediate return to IDLE. No strobe or reply is generated for the interrupted command.

Decomposition:
- Shared package holds the opcode constants OP_WRITE=8'h57 and OP_READ=8'h52, the reply constants RSP_OK=8'h4B and RSP_ERR=8'h3F, and the state encoding as a typedef.
- The timeout counter is a natural sub-module: uart_byte_timeout (clear, enable, expired output, parameters TN and Timeout).
- Everything else lives in one FSM.

Test Plan:
- Write: send bytes 57,10,A5 with Tx_Busy=0 -> one Bus_Write cycle with Bus_Address=10 and Bus_WrData=A5, then Tx_Send with Tx_Data=4B. Exactly 3 Rx_Ack pulses.
- Read: send bytes 52,22 with Bus_RdData=3C the cycle after Bus_Read -> one Bus_Read with Bus_Address=22, then Tx_Send with Tx_Data=3C. No Bus_Write.
- Bad opcode: send byte 41 -> no bus strobe, Tx_Send with Tx_Data=3F, state back to IDLE (Busy=0) after Tx_Busy falls.
- Timeout: Timeout=16'd20, send 57,10, then no byte for 25 cycles -> IDLE, no strobe, no Tx_Send. A following 52,10 is executed normally.
- Tx back-pressure: hold Tx_Busy=1 for 100 cycles after a 57,01,02 write -> Tx_Send waits until Tx_Busy=0, then pulses once. A byte arriving meanwhile is not acknowledged until IDLE.
- Reset mid-command: pull Reset low after 57,05 -> all outputs return to reset values immediately. After release, no strobe or reply occurs for the aborted command.
